// File: rtl/rdy_vld_rr_arb.sv
// Round-robin N-to-1 ready/valid arbiter with a single registered output stage.
// Optional packet locking (in_last port + lock FSM) is enabled by defining RDY_VLD_ARB_LOCK_EN.
module rdy_vld_rr_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        in_vld,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
`ifdef RDY_VLD_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        in_last,
`endif
  output logic [NUM_REQ-1:0]        in_rdy,
  output logic                      out_vld,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_src,
  input  logic                      out_rdy
);

  localparam logic [IDX_W:0] NREQ_EXT = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0]  r_ptr;
  logic              w_rr_vld;
  logic [IDX_W-1:0]  w_rr_idx;
  logic              w_grant_vld;
  logic [IDX_W-1:0]  w_grant_idx;
  logic              w_stage_free;
  logic              w_xfer;
  logic [DATA_W-1:0] w_sel_data;

  // (base + ofs) mod NUM_REQ; ofs never exceeds NUM_REQ so one subtraction suffices.
  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int unsigned ofs);
    logic [IDX_W:0] v_sum;
    v_sum = {1'b0, base} + (IDX_W+1)'(ofs);
    if (v_sum >= NREQ_EXT) v_sum = v_sum - NREQ_EXT;
    return v_sum[IDX_W-1:0];
  endfunction

  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_rr_vld && in_vld[f_wrap(r_ptr, k)]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = f_wrap(r_ptr, k);
      end
    end
  end

  assign w_stage_free = ~out_vld | out_rdy;

`ifdef RDY_VLD_ARB_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_lock_idx, w_lock_idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  // While locked, only the packet owner can be granted, even if it pauses.
  always_comb begin
    w_grant_vld    = w_rr_vld;
    w_grant_idx    = w_rr_idx;
    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    if (r_state == S_LOCKED) begin
      w_grant_vld = in_vld[r_lock_idx];
      w_grant_idx = r_lock_idx;
    end
    if (w_grant_vld && w_stage_free && !rst) begin
      if (in_last[w_grant_idx]) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt    = S_LOCKED;
        w_lock_idx_nxt = w_grant_idx;
      end
    end
  end
`else
  assign w_grant_vld = w_rr_vld;
  assign w_grant_idx = w_rr_idx;
`endif

  assign w_xfer     = w_grant_vld & w_stage_free & ~rst;
  assign w_sel_data = in_data[w_grant_idx*DATA_W +: DATA_W];

  always_comb begin
    in_rdy = '0;
    if (w_xfer) in_rdy[w_grant_idx] = 1'b1;
  end

  // Output stage: reloads on transfer, empties on a bare output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      r_ptr    <= IDX_W'(NUM_REQ-1);
    end else if (w_xfer) begin
      out_vld  <= 1'b1;
      out_data <= w_sel_data;
      out_src  <= w_grant_idx;
      r_ptr    <= w_grant_idx;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rdy_vld_rr_arb.sv
// Directed and randomized self-checking bench for rdy_vld_rr_arb (NUM_REQ=4, DATA_W=32).
// Lock scenario is exercised when RDY_VLD_ARB_LOCK_EN is defined.
module tb_rdy_vld_rr_arb;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        in_vld = '0;
  logic [NUM_REQ*DATA_W-1:0] in_data = '0;
`ifdef RDY_VLD_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        in_last = '1;
`endif
  logic [NUM_REQ-1:0]        in_rdy;
  logic                      out_vld;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_src;
  logic                      out_rdy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  rdy_vld_rr_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
`ifdef RDY_VLD_ARB_LOCK_EN
    .in_last(in_last),
`endif
    .in_rdy(in_rdy), .out_vld(out_vld), .out_data(out_data),
    .out_src(out_src), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] tag(input int src, input int seq);
    return {8'(src), 24'(seq)};
  endfunction

  task automatic load_tags(input int seq);
    for (int i = 0; i < NUM_REQ; i++) in_data[i*DATA_W +: DATA_W] = tag(i, seq);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_vld = '0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL reset_out_vld got=%b exp=0", out_vld); n_fail++; end
    n_checks++; if (out_data !== '0) begin $display("FAIL reset_out_data got=%h exp=0", out_data); n_fail++; end
    n_checks++; if (out_src !== '0) begin $display("FAIL reset_out_src got=%0d exp=0", out_src); n_fail++; end
    n_checks++; if (in_rdy !== '0) begin $display("FAIL reset_in_rdy got=%b exp=0000", in_rdy); n_fail++; end
  endtask

  task automatic test_round_robin();
    do_reset();
    load_tags(7);
    in_vld = 4'b1111; out_rdy = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 4'b0001) begin $display("FAIL rr_first_rdy got=%b exp=0001", in_rdy); n_fail++; end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++; if (out_vld !== 1'b1) begin $display("FAIL rr_vld[%0d] got=%b exp=1", k, out_vld); n_fail++; end
      n_checks++; if (out_src !== IDX_W'(k % 4)) begin $display("FAIL rr_src[%0d] got=%0d exp=%0d", k, out_src, k % 4); n_fail++; end
      n_checks++; if (out_data !== tag(k % 4, 7)) begin $display("FAIL rr_data[%0d] got=%h exp=%h", k, out_data, tag(k % 4, 7)); n_fail++; end
    end
    @(negedge clk); in_vld = '0;
    @(posedge clk); #1;
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL rr_drain_vld got=%b exp=0", out_vld); n_fail++; end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_tags(3);
    in_vld = 4'b0101; out_rdy = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd0 || out_vld !== 1'b1) begin $display("FAIL bp_first got src=%0d vld=%b exp src=0 vld=1", out_src, out_vld); n_fail++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_checks++; if (in_rdy !== 4'b0000) begin $display("FAIL bp_hold_rdy[%0d] got=%b exp=0000", k, in_rdy); n_fail++; end
      n_checks++; if (out_src !== 2'd0 || out_data !== tag(0, 3) || out_vld !== 1'b1) begin
        $display("FAIL bp_hold_out[%0d] got src=%0d data=%h vld=%b exp src=0 data=%h vld=1", k, out_src, out_data, out_vld, tag(0, 3)); n_fail++; end
    end
    @(negedge clk); out_rdy = 1'b1; #1;
    n_checks++; if (in_rdy !== 4'b0100) begin $display("FAIL bp_release_rdy got=%b exp=0100", in_rdy); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd2 || out_data !== tag(2, 3)) begin $display("FAIL bp_next1 got src=%0d data=%h exp src=2 data=%h", out_src, out_data, tag(2, 3)); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd0 || out_vld !== 1'b1) begin $display("FAIL bp_next2 got src=%0d vld=%b exp src=0 vld=1", out_src, out_vld); n_fail++; end
    @(negedge clk); in_vld = '0;
  endtask

  task automatic test_single();
    do_reset();
    in_data = '0;
    in_data[3*DATA_W +: DATA_W] = 32'hA5A5_A5A5;
    in_vld = 4'b1000; out_rdy = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 4'b1000) begin $display("FAIL single_rdy got=%b exp=1000", in_rdy); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_vld !== 1'b1 || out_data !== 32'hA5A5_A5A5 || out_src !== 2'd3) begin
      $display("FAIL single_out got vld=%b data=%h src=%0d exp vld=1 data=a5a5a5a5 src=3", out_vld, out_data, out_src); n_fail++; end
    @(negedge clk); in_vld = '0;
    @(posedge clk); #1;
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL single_drain got=%b exp=0", out_vld); n_fail++; end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_tags(9);
    in_vld = 4'b1111; out_rdy = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_vld !== 1'b1) begin $display("FAIL rmid_pre_vld got=%b exp=1", out_vld); n_fail++; end
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (out_vld !== 1'b0 || in_rdy !== 4'b0000) begin $display("FAIL rmid_async got vld=%b rdy=%b exp vld=0 rdy=0000", out_vld, in_rdy); n_fail++; end
    @(negedge clk); rst = 1'b0; out_rdy = 1'b1; #1;
    n_checks++; if (in_rdy !== 4'b0001) begin $display("FAIL rmid_rdy_after got=%b exp=0001", in_rdy); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd0 || out_vld !== 1'b1) begin $display("FAIL rmid_first got src=%0d vld=%b exp src=0 vld=1", out_src, out_vld); n_fail++; end
    @(negedge clk); in_vld = '0;
  endtask

`ifdef RDY_VLD_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    load_tags(0);
    in_last = 4'b0000; in_vld = 4'b0110; out_rdy = 1'b1; #1;
    n_checks++; if (in_rdy !== 4'b0010) begin $display("FAIL lock_w0_rdy got=%b exp=0010", in_rdy); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd1) begin $display("FAIL lock_w0_src got=%0d exp=1", out_src); n_fail++; end
    @(negedge clk); in_vld = 4'b0100; #1;
    n_checks++; if (in_rdy !== 4'b0000) begin $display("FAIL lock_gap_rdy got=%b exp=0000", in_rdy); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL lock_gap_vld got=%b exp=0", out_vld); n_fail++; end
    @(negedge clk); load_tags(1); in_vld = 4'b0110; #1;
    n_checks++; if (in_rdy !== 4'b0010) begin $display("FAIL lock_w1_rdy got=%b exp=0010", in_rdy); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd1 || out_data !== tag(1, 1)) begin $display("FAIL lock_w1_out got src=%0d data=%h exp src=1 data=%h", out_src, out_data, tag(1, 1)); n_fail++; end
    @(negedge clk); load_tags(2); in_last = 4'b0010;
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd1 || out_data !== tag(1, 2)) begin $display("FAIL lock_w2_out got src=%0d data=%h exp src=1 data=%h", out_src, out_data, tag(1, 2)); n_fail++; end
    @(negedge clk); in_vld = 4'b0100; #1;
    n_checks++; if (in_rdy !== 4'b0100) begin $display("FAIL lock_unlock_rdy got=%b exp=0100", in_rdy); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (out_src !== 2'd2) begin $display("FAIL lock_after_src got=%0d exp=2", out_src); n_fail++; end
    @(negedge clk); in_vld = '0; in_last = '1;
  endtask
`endif

  task automatic test_random();
    int seq_tx[NUM_REQ];
    int seq_rx[NUM_REQ];
    int wait_cnt[NUM_REQ];
    logic [NUM_REQ-1:0] xf;
    do_reset();
    xf = '0;
    for (int i = 0; i < NUM_REQ; i++) begin seq_tx[i] = 0; seq_rx[i] = 0; wait_cnt[i] = 0; end
    for (int c = 0; c < 10040; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xf[i]) begin seq_tx[i]++; in_vld[i] = 1'b0; end
        if (!in_vld[i] && c < 10000 && $urandom_range(0, 2) != 0) in_vld[i] = 1'b1;
        in_data[i*DATA_W +: DATA_W] = tag(i, seq_tx[i]);
      end
      out_rdy = (c >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      xf = in_rdy & in_vld;
      n_checks++; if ($countones(in_rdy) > 1) begin $display("FAIL rnd_onehot c=%0d got=%b exp<=1 bit", c, in_rdy); n_fail++; end
      if (xf != '0) begin
        int worst;
        worst = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (xf[i]) wait_cnt[i] = 0;
          else if (in_vld[i]) wait_cnt[i]++;
          if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        n_checks++; if (worst > NUM_REQ - 1) begin $display("FAIL rnd_fair c=%0d got wait=%0d exp<=%0d", c, worst, NUM_REQ - 1); n_fail++; end
      end
      if (out_vld && out_rdy) begin
        n_checks++; if (out_data !== tag(int'(out_src), seq_rx[out_src])) begin
          $display("FAIL rnd_word c=%0d src=%0d got=%h exp=%h", c, out_src, out_data, tag(int'(out_src), seq_rx[out_src])); n_fail++; end
        seq_rx[out_src]++;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      n_checks++; if (seq_rx[i] != seq_tx[i] || seq_tx[i] == 0) begin
        $display("FAIL rnd_count src=%0d got rx=%0d exp tx=%0d (nonzero)", i, seq_rx[i], seq_tx[i]); n_fail++; end
    end
    n_checks++; if (out_vld !== 1'b0 || in_vld !== '0) begin $display("FAIL rnd_drained got vld=%b in_vld=%b exp 0", out_vld, in_vld); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single();
    test_reset_mid();
`ifdef RDY_VLD_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
